// File: rtl/uart_string_pkg.sv
// Shared definitions for the UART command-string receiver.
// Holds the ASCII command characters and the state encodings of the
// byte receiver FSM and the command parser FSM.
package uart_string_pkg;

    // ASCII characters that make up a "L<f>:<h>\n" command
    localparam logic [7:0] CH_L     = 8'h4C;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_1     = 8'h31;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        P_WAIT_L,
        P_GET_F,
        P_GET_COLON,
        P_GET_H,
        P_WAIT_NL
    } parse_state_e;

    // True for the two ASCII digits accepted as LED values
    function automatic logic is_bin_digit(input logic [7:0] c);
        return (c == CH_0) || (c == CH_1);
    endfunction

endpackage

// File: rtl/uart_string_rx.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer.
// Ports: clk_i, rst_i (sync, active high), rx_i (async serial in),
//        rx_byte_o / rx_valid_o (one-cycle pulse per good byte).
module uart_string_rx
    import uart_string_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;

    // Synchronizer and edge-detect history reset to the idle (high) level
    // so that a reset never fabricates a falling edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                // A true 1->0 edge is required, so a line left low after a
                // framing error does not restart reception.
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    // Line back high at mid start bit: treat as a glitch
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};  // LSB arrives first
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    // Low stop bit is a framing error: drop the byte silently
                    if (rx_sync_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte_o  = byte_q;
    assign rx_valid_o = valid_q;

endmodule

// File: rtl/uart_string.sv
// UART command parser driving the fan and humidifier LEDs from "L<f>:<h>\n".
// Ports: clk_100Mhz, rst_n (sync, active HIGH despite the name), rx (serial
//        in, idles high), led_fan / led_hum (registered, update on '\n').
module uart_string
    import uart_string_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic clk_100Mhz,
    input  logic rst_n,
    input  logic rx,
    output logic led_fan,
    output logic led_hum
);

    localparam int unsigned CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;

    logic [7:0] rx_byte;
    logic       rx_valid;

    uart_string_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i      (clk_100Mhz),
        .rst_i      (rst_n),
        .rx_i       (rx),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid)
    );

    parse_state_e state_q, state_d;
    logic         f_q, f_d;
    logic         h_q, h_d;
    logic         led_fan_q, led_fan_d;
    logic         led_hum_q, led_hum_d;

    always_ff @(posedge clk_100Mhz) begin
        if (rst_n) begin
            state_q   <= P_WAIT_L;
            f_q       <= 1'b0;
            h_q       <= 1'b0;
            led_fan_q <= 1'b0;
            led_hum_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            h_q       <= h_d;
            led_fan_q <= led_fan_d;
            led_hum_q <= led_hum_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        h_d       = h_q;
        led_fan_d = led_fan_q;
        led_hum_d = led_hum_q;

        if (rx_valid) begin
            // Default for any unexpected byte: abort, but an 'L' starts a
            // fresh command immediately instead of being lost.
            state_d = (rx_byte == CH_L) ? P_GET_F : P_WAIT_L;

            unique case (state_q)
                P_WAIT_L: begin
                    // default handling above already covers this state
                end
                P_GET_F: begin
                    if (is_bin_digit(rx_byte)) begin
                        f_d     = rx_byte[0];
                        state_d = P_GET_COLON;
                    end
                end
                P_GET_COLON: begin
                    if (rx_byte == CH_COLON) begin
                        state_d = P_GET_H;
                    end
                end
                P_GET_H: begin
                    if (is_bin_digit(rx_byte)) begin
                        h_d     = rx_byte[0];
                        state_d = P_WAIT_NL;
                    end
                end
                P_WAIT_NL: begin
                    if (rx_byte == CH_LF) begin
                        // Both LEDs change together only on a complete command
                        led_fan_d = f_q;
                        led_hum_d = h_q;
                        state_d   = P_WAIT_L;
                    end else if (rx_byte == CH_CR) begin
                        state_d = P_WAIT_NL;
                    end
                end
                default: state_d = P_WAIT_L;
            endcase
        end
    end

    assign led_fan = led_fan_q;
    assign led_hum = led_hum_q;

endmodule

// File: tb/tb_uart_string.sv
// Self-checking bench for uart_string, run at a reduced clock rate so that
// each UART bit is 16 clocks. The reference model keeps the history of good
// bytes and accepts a command when it ends in  L [01] : [01] CR* LF.
module tb_uart_string;

    localparam int unsigned CLK_FREQ = 153_600;
    localparam int unsigned BAUD     = 9600;
    localparam int unsigned CPB      = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int unsigned GAP      = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rx = 1'b1;
    logic led_fan, led_hum;

    int vectors = 0;
    int miscompares = 0;

    byte unsigned hist[$];
    logic exp_fan = 1'b0;
    logic exp_hum = 1'b0;

    always #5 clk = ~clk;

    uart_string #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk_100Mhz(clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .led_fan   (led_fan),
        .led_hum   (led_hum)
    );

    // ---------------- reference model ----------------
    function automatic bit is_dig(input byte unsigned c);
        return (c == 8'h30) || (c == 8'h31);
    endfunction

    function automatic bit cmd_ok(output bit f, output bit h);
        int i;
        f = 1'b0;
        h = 1'b0;
        i = hist.size() - 2;  // byte before the final LF
        while (i >= 0 && hist[i] == 8'h0D) i--;
        if (i < 3) return 1'b0;
        if (!is_dig(hist[i]) || hist[i-1] != 8'h3A || !is_dig(hist[i-2]) || hist[i-3] != 8'h4C)
            return 1'b0;
        f = hist[i-2][0];
        h = hist[i][0];
        return 1'b1;
    endfunction

    function automatic void model_push(input byte unsigned b, input bit stop_ok);
        bit f, h;
        if (!stop_ok) return;
        hist.push_back(b);
        if (b == 8'h0A && cmd_ok(f, h)) begin
            exp_fan = f;
            exp_hum = h;
        end
    endfunction

    function automatic void model_reset();
        hist.delete();
        exp_fan = 1'b0;
        exp_hum = 1'b0;
    endfunction

    // ---------------- stimulus ----------------
    task automatic send_byte(input byte unsigned b, input bit stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (GAP) @(negedge clk);
        model_push(b, stop_ok);
    endtask

    task automatic test_reset();
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        vectors++;
        if ({led_fan, led_hum} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset: leds=%b expected 00", {led_fan, led_hum});
        end
    endtask

    task automatic test_single_cmd();
        string s = "L1:0\n";
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1);
            vectors++;
            if ({led_fan, led_hum} !== {exp_fan, exp_hum}) begin
                miscompares++;
                $display("FAIL single byte%0d: leds=%b expected %b", i, {led_fan, led_hum}, {exp_fan, exp_hum});
            end
        end
        vectors++;
        if ({led_fan, led_hum} !== 2'b10) begin
            miscompares++;
            $display("FAIL single final: leds=%b expected 10", {led_fan, led_hum});
        end
    endtask

    task automatic test_two_cmds();
        string s[2] = '{"L0:1\n", "L1:1\n"};
        logic [1:0] want[2] = '{2'b01, 2'b11};
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < s[c].len(); i++) begin
                send_byte(s[c][i], 1'b1);
                vectors++;
                if ({led_fan, led_hum} !== {exp_fan, exp_hum}) begin
                    miscompares++;
                    $display("FAIL two cmd%0d byte%0d: leds=%b expected %b", c, i, {led_fan, led_hum}, {exp_fan, exp_hum});
                end
            end
            vectors++;
            if ({led_fan, led_hum} !== want[c]) begin
                miscompares++;
                $display("FAIL two cmd%0d final: leds=%b expected %b", c, {led_fan, led_hum}, want[c]);
            end
        end
    endtask

    task automatic test_reject();
        string s = "L1:2\nX0:0\n";
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1);
            vectors++;
            if ({led_fan, led_hum} !== 2'b11) begin
                miscompares++;
                $display("FAIL reject byte%0d: leds=%b expected 11", i, {led_fan, led_hum});
            end
        end
    endtask

    task automatic test_resync();
        string s[3] = '{"L0:L0:0\n", "L1:1\r\n", "L0:0\r\n"};
        logic [1:0] want[3] = '{2'b00, 2'b11, 2'b00};
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < s[c].len(); i++) begin
                send_byte(s[c][i], 1'b1);
                vectors++;
                if ({led_fan, led_hum} !== {exp_fan, exp_hum}) begin
                    miscompares++;
                    $display("FAIL resync cmd%0d byte%0d: leds=%b expected %b", c, i, {led_fan, led_hum}, {exp_fan, exp_hum});
                end
            end
            vectors++;
            if ({led_fan, led_hum} !== want[c]) begin
                miscompares++;
                $display("FAIL resync cmd%0d final: leds=%b expected %b", c, {led_fan, led_hum}, want[c]);
            end
        end
    endtask

    task automatic test_glitch_framing();
        string s = "L1:1\n";
        // Short low pulse, well under half a bit
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        // Command with a framing error on the colon: must abort
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], (i != 2));
            vectors++;
            if ({led_fan, led_hum} !== 2'b00) begin
                miscompares++;
                $display("FAIL framing byte%0d: leds=%b expected 00", i, {led_fan, led_hum});
            end
        end
        // Same command clean: accepted
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        vectors++;
        if ({led_fan, led_hum} !== 2'b11) begin
            miscompares++;
            $display("FAIL framing clean: leds=%b expected 11", {led_fan, led_hum});
        end
    endtask

    task automatic test_reset_mid_byte();
        string s = "L1:0\n";
        @(negedge clk);
        rx = 1'b0;                      // start bit
        repeat (CPB) @(negedge clk);
        rx = 1'b1;                      // bit 0
        repeat (CPB) @(negedge clk);
        rx = 1'b0;                      // part of bit 1
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        model_reset();
        @(negedge clk);
        vectors++;
        if ({led_fan, led_hum} !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset: leds=%b expected 00", {led_fan, led_hum});
        end
        repeat (12 * CPB) @(negedge clk);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        vectors++;
        if ({led_fan, led_hum} !== 2'b10) begin
            miscompares++;
            $display("FAIL midreset cmd: leds=%b expected 10", {led_fan, led_hum});
        end
    endtask

    task automatic test_random();
        byte unsigned alpha[7] = '{8'h4C, 8'h30, 8'h31, 8'h3A, 8'h0A, 8'h0D, 8'h58};
        byte unsigned cmd[$];
        for (int c = 0; c < 14; c++) begin
            cmd.delete();
            cmd.push_back(8'h4C);
            cmd.push_back(8'h30 + 8'($urandom_range(0, 1)));
            cmd.push_back(8'h3A);
            cmd.push_back(8'h30 + 8'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) cmd.push_back(8'h0D);
            cmd.push_back(8'h0A);
            if ($urandom_range(0, 2) == 0)
                cmd[$urandom_range(0, cmd.size() - 1)] = alpha[$urandom_range(0, 6)];
            for (int i = 0; i < cmd.size(); i++) begin
                send_byte(cmd[i], ($urandom_range(0, 9) != 0));
                vectors++;
                if ({led_fan, led_hum} !== {exp_fan, exp_hum}) begin
                    miscompares++;
                    $display("FAIL random cmd%0d byte%0d: leds=%b expected %b", c, i, {led_fan, led_hum}, {exp_fan, exp_hum});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_two_cmds();
        test_reject();
        test_resync();
        test_glitch_framing();
        test_reset_mid_byte();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
